// File: rtl/jk_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_arbiter
// Purpose  : Shares one bank of WIDTH external JK flip-flop cells between two
//            requesters (A and B). A request is arbitrated in IDLE, its
//            operation is driven onto the bank for one cycle (GRANT), the bank
//            is given one quiet cycle (SETTLE), and then the winner receives a
//            one-cycle acknowledge with the post-operation Q[Idx] (RESP).
//
// Ports    : CLK              clock, shared with the JK bank
//            Clr              synchronous active-high reset
//            ReqA/OpA/IdxA    requester A request, opcode, target bit
//            AckA             one-cycle completion pulse to A
//            ReqB/OpB/IdxB    requester B request, opcode, target bit
//            AckB             one-cycle completion pulse to B
//            Q                current Q outputs of the bank cells
//            J/K              per-cell J and K drives
//            ClrN/PreN        bank-wide clear / preset, active low
//            RdData           Q[Idx] of the completed operation (with Ack)
//            Err              Idx >= WIDTH for an indexed opcode (with Ack)
//            Busy             operation in flight (GRANT, SETTLE, RESP)
//
// Opcodes  : 000 NOP, 001 SET, 010 RESET, 011 TOGGLE, 100 CLEAR_ALL,
//            101 PRESET_ALL, 110 READ, 111 reserved (NOP)
//
// Config   : JK_ARB_RR_EN defined   -> round-robin arbitration (last-grant
//                                      pointer, resets to B so A wins first)
//            JK_ARB_RR_EN undefined -> fixed priority, A always wins ties
//
// Revision : 1.0  initial release
// ============================================================================
module jk_bank_arbiter #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
) (
  input  logic             CLK,
  input  logic             Clr,
  input  logic             ReqA,
  input  logic [2:0]       OpA,
  input  logic [IDX_W-1:0] IdxA,
  output logic             AckA,
  input  logic             ReqB,
  input  logic [2:0]       OpB,
  input  logic [IDX_W-1:0] IdxB,
  output logic             AckB,
  input  logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             ClrN,
  output logic             PreN,
  output logic             RdData,
  output logic             Err,
  output logic             Busy
);

  // --------------------------------------------------------------------------
  // Opcode encodings
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_OP_NOP        = 3'b000;
  localparam logic [2:0] c_OP_SET        = 3'b001;
  localparam logic [2:0] c_OP_RESET      = 3'b010;
  localparam logic [2:0] c_OP_TOGGLE     = 3'b011;
  localparam logic [2:0] c_OP_CLEAR_ALL  = 3'b100;
  localparam logic [2:0] c_OP_PRESET_ALL = 3'b101;
  localparam logic [2:0] c_OP_READ       = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_SETTLE = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Opcodes that address a single cell and can therefore be out of range.
  function automatic logic op_indexed(input logic [2:0] op);
    return (op == c_OP_SET)    || (op == c_OP_RESET) ||
           (op == c_OP_TOGGLE) || (op == c_OP_READ);
  endfunction

  // --------------------------------------------------------------------------
  // State and latched command
  // --------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             win_b_q, win_b_d;   // 1: B owns the in-flight operation

  // Registered outputs
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             clrn_q, clrn_d;
  logic             pren_q, pren_d;
  logic             acka_q, acka_d;
  logic             ackb_q, ackb_d;
  logic             rd_q, rd_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  // Arbitration result: 1 selects B
  logic             w_pick_b;

  // One-hot decodes of the index being granted (idx_d) and the index of the
  // operation in flight (idx_q). An out-of-range index decodes to all zeros,
  // which suppresses J/K and forces RdData to 0 without a separate compare.
  logic [WIDTH-1:0] w_sel_d;
  logic [WIDTH-1:0] w_sel_q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sel
    assign w_sel_d[gi] = (idx_d == IDX_W'(gi));
    assign w_sel_q[gi] = (idx_q == IDX_W'(gi));
  end

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
`ifdef JK_ARB_RR_EN
  // Last-grant pointer: 1 means B was granted last. On a tie the requester
  // that was not granted last wins.
  logic last_b_q, last_b_d;

  assign w_pick_b = ReqB & (~ReqA | ~last_b_q);

  always_comb begin
    last_b_d = last_b_q;
    if ((state_q == S_IDLE) && (ReqA || ReqB)) begin
      last_b_d = w_pick_b;
    end
  end

  always_ff @(posedge CLK) begin
    if (Clr) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end
`else
  // Fixed priority: A wins every tie, B is served only when A is idle.
  assign w_pick_b = ReqB & ~ReqA;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    win_b_d = win_b_q;
    case (state_q)
      S_IDLE: begin
        if (ReqA || ReqB) begin
          state_d = S_GRANT;
          win_b_d = w_pick_b;
          op_d    = w_pick_b ? OpB  : OpA;
          idx_d   = w_pick_b ? IdxB : IdxA;
        end
      end
      S_GRANT:  state_d = S_SETTLE;
      S_SETTLE: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output next-values. Every output is registered, so the values for a state
  // are computed from the state being entered (state_d). The bank drive for
  // GRANT therefore comes from the command being latched in the same edge.
  // --------------------------------------------------------------------------
  always_comb begin
    j_d    = '0;
    k_d    = '0;
    clrn_d = 1'b1;
    pren_d = 1'b1;
    acka_d = 1'b0;
    ackb_d = 1'b0;
    rd_d   = 1'b0;
    err_d  = 1'b0;
    busy_d = (state_d != S_IDLE);

    if (state_d == S_GRANT) begin
      case (op_d)
        c_OP_SET:        j_d    = w_sel_d;
        c_OP_RESET:      k_d    = w_sel_d;
        c_OP_TOGGLE: begin
                         j_d    = w_sel_d;
                         k_d    = w_sel_d;
        end
        c_OP_CLEAR_ALL:  clrn_d = 1'b0;
        c_OP_PRESET_ALL: pren_d = 1'b0;
        default:         ;  // NOP, READ and reserved leave the bank alone
      endcase
    end

    // Entering RESP: Q has had the SETTLE cycle to reflect the operation, so
    // the value captured at this edge is the post-operation state.
    if (state_d == S_RESP) begin
      acka_d = ~win_b_q;
      ackb_d = win_b_q;
      rd_d   = |(Q & w_sel_q);
      err_d  = op_indexed(op_q) & ~(|w_sel_q);
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (Clr) begin
      state_q <= S_IDLE;
      op_q    <= c_OP_NOP;
      idx_q   <= '0;
      win_b_q <= 1'b0;
      j_q     <= '0;
      k_q     <= '0;
      clrn_q  <= 1'b1;
      pren_q  <= 1'b1;
      acka_q  <= 1'b0;
      ackb_q  <= 1'b0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      win_b_q <= win_b_d;
      j_q     <= j_d;
      k_q     <= k_d;
      clrn_q  <= clrn_d;
      pren_q  <= pren_d;
      acka_q  <= acka_d;
      ackb_q  <= ackb_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign J      = j_q;
  assign K      = k_q;
  assign ClrN   = clrn_q;
  assign PreN   = pren_q;
  assign AckA   = acka_q;
  assign AckB   = ackb_q;
  assign RdData = rd_q;
  assign Err    = err_q;
  assign Busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_bank_arbiter
// Purpose  : Directed self-checking bench for jk_bank_arbiter. A behavioural
//            JK bank is attached to each DUT instance (WIDTH=4 and WIDTH=3).
// Revision : 1.0  initial release
// ============================================================================
module tb_jk_bank_arbiter;

  localparam logic [2:0] c_NOP = 3'b000, c_SET = 3'b001, c_RST = 3'b010,
                         c_TGL = 3'b011, c_CLA = 3'b100, c_PRA = 3'b101,
                         c_RD  = 3'b110;

  logic       CLK = 1'b0;
  logic       Clr;
  logic       ReqA, ReqB;
  logic [2:0] OpA, OpB;
  logic [1:0] IdxA, IdxB;
  logic       AckA, AckB;
  logic [3:0] Q = 4'b0000;
  logic [3:0] J, K;
  logic       ClrN, PreN, RdData, Err, Busy;

  // WIDTH=3 instance signals
  logic       ReqA3;
  logic [2:0] OpA3;
  logic [1:0] IdxA3;
  logic       AckA3, AckB3;
  logic       ReqB3 = 1'b0;
  logic [2:0] OpB3  = 3'b000;
  logic [1:0] IdxB3 = 2'b00;
  logic [2:0] Q3 = 3'b000;
  logic [2:0] J3, K3;
  logic       ClrN3, PreN3, RdData3, Err3, Busy3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  jk_bank_arbiter #(.WIDTH(4), .IDX_W(2)) u_dut (
    .CLK(CLK), .Clr(Clr),
    .ReqA(ReqA), .OpA(OpA), .IdxA(IdxA), .AckA(AckA),
    .ReqB(ReqB), .OpB(OpB), .IdxB(IdxB), .AckB(AckB),
    .Q(Q), .J(J), .K(K), .ClrN(ClrN), .PreN(PreN),
    .RdData(RdData), .Err(Err), .Busy(Busy)
  );

  jk_bank_arbiter #(.WIDTH(3), .IDX_W(2)) u_dut3 (
    .CLK(CLK), .Clr(Clr),
    .ReqA(ReqA3), .OpA(OpA3), .IdxA(IdxA3), .AckA(AckA3),
    .ReqB(ReqB3), .OpB(OpB3), .IdxB(IdxB3), .AckB(AckB3),
    .Q(Q3), .J(J3), .K(K3), .ClrN(ClrN3), .PreN(PreN3),
    .RdData(RdData3), .Err(Err3), .Busy(Busy3)
  );

  // Behavioural JK banks
  always @(posedge CLK) begin
    if (ClrN === 1'b0)      Q <= 4'b0000;
    else if (PreN === 1'b0) Q <= 4'b1111;
    else for (int i = 0; i < 4; i++)
      case ({J[i], K[i]})
        2'b10:   Q[i] <= 1'b1;
        2'b01:   Q[i] <= 1'b0;
        2'b11:   Q[i] <= ~Q[i];
        default: ;
      endcase
  end

  always @(posedge CLK) begin
    if (ClrN3 === 1'b0)      Q3 <= 3'b000;
    else if (PreN3 === 1'b0) Q3 <= 3'b111;
    else for (int i = 0; i < 3; i++)
      case ({J3[i], K3[i]})
        2'b10:   Q3[i] <= 1'b1;
        2'b01:   Q3[i] <= 1'b0;
        2'b11:   Q3[i] <= ~Q3[i];
        default: ;
      endcase
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Clr = 1'b1;
    ReqA = 1'b0; OpA = c_NOP; IdxA = 2'd0;
    ReqB = 1'b0; OpB = c_NOP; IdxB = 2'd0;
    ReqA3 = 1'b0; OpA3 = c_NOP; IdxA3 = 2'd0;
    tick();
    tick();
    Clr = 1'b0;
  endtask

  // Issue one operation on the WIDTH=4 DUT from an idle start and observe it.
  task automatic run_op(input bit sel_b, input logic [2:0] op, input logic [1:0] idx,
                        output logic [3:0] gj, output logic [3:0] gk,
                        output logic gclrn, output logic gpren,
                        output logic [3:0] sj, output logic [3:0] sk,
                        output logic sclrn, output logic spren,
                        output int ackcyc, output logic rd, output logic er,
                        output bit wrong_ack, output logic ack_after);
    gj = 'x; gk = 'x; gclrn = 'x; gpren = 'x;
    sj = 'x; sk = 'x; sclrn = 'x; spren = 'x;
    ackcyc = 0; rd = 1'bx; er = 1'bx; wrong_ack = 1'b0;
    if (sel_b) begin ReqB = 1'b1; OpB = op; IdxB = idx; end
    else       begin ReqA = 1'b1; OpA = op; IdxA = idx; end
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) begin gj = J; gk = K; gclrn = ClrN; gpren = PreN; end
      if (c == 2) begin sj = J; sk = K; sclrn = ClrN; spren = PreN; end
      if (sel_b ? AckA : AckB) wrong_ack = 1'b1;
      if (sel_b ? AckB : AckA) begin
        ackcyc = c; rd = RdData; er = Err;
        break;
      end
    end
    ReqA = 1'b0; ReqB = 1'b0;
    tick();
    ack_after = AckA | AckB;
  endtask

  // Issue one operation from A on the WIDTH=3 DUT; jk_or collects all J/K.
  task automatic run_op3(input logic [2:0] op, input logic [1:0] idx,
                         output logic [2:0] jk_or, output int ackcyc,
                         output logic rd, output logic er);
    jk_or = 3'b000; ackcyc = 0; rd = 1'bx; er = 1'bx;
    ReqA3 = 1'b1; OpA3 = op; IdxA3 = idx;
    for (int c = 1; c <= 8; c++) begin
      tick();
      jk_or = jk_or | J3 | K3;
      if (AckA3) begin ackcyc = c; rd = RdData3; er = Err3; break; end
    end
    ReqA3 = 1'b0;
    tick();
    jk_or = jk_or | J3 | K3;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({J, K, ClrN, PreN, AckA, AckB, RdData, Err, Busy} !== 15'b00000000_11_00000) begin
      n_fail++;
      $display("FAIL reset_outputs: got J=%b K=%b ClrN=%b PreN=%b AckA=%b AckB=%b Rd=%b Err=%b Busy=%b, want 0000 0000 1 1 0 0 0 0 0",
               J, K, ClrN, PreN, AckA, AckB, RdData, Err, Busy);
    end
    n_checks++;
    if ({J3, K3, ClrN3, PreN3, AckA3, AckB3, RdData3, Err3, Busy3} !== 13'b000_000_11_00000) begin
      n_fail++;
      $display("FAIL reset_outputs_w3: got J=%b K=%b ClrN=%b PreN=%b Busy=%b, want reset values",
               J3, K3, ClrN3, PreN3, Busy3);
    end
    tick();
    n_checks++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_busy: got %b want 0", Busy);
    end
  endtask

  task automatic test_set();
    logic [3:0] gj, gk, sj, sk;
    logic gclrn, gpren, sclrn, spren, rd, er, aa;
    int ac;
    bit wa;
    do_reset();
    run_op(1'b0, c_SET, 2'd2, gj, gk, gclrn, gpren, sj, sk, sclrn, spren, ac, rd, er, wa, aa);
    n_checks++;
    if ({gj, gk} !== 8'b0100_0000) begin
      n_fail++; $display("FAIL set_grant_jk: got J=%b K=%b want J=0100 K=0000", gj, gk);
    end
    n_checks++;
    if ({sj, sk, gclrn, gpren} !== 10'b0000_0000_11) begin
      n_fail++; $display("FAIL set_settle_jk: got J=%b K=%b ClrN=%b PreN=%b want 0000 0000 1 1", sj, sk, gclrn, gpren);
    end
    n_checks++;
    if (ac !== 3) begin
      n_fail++; $display("FAIL set_ack_cycle: got %0d want 3", ac);
    end
    n_checks++;
    if ({rd, er, wa, aa} !== 4'b1000) begin
      n_fail++; $display("FAIL set_resp: got Rd=%b Err=%b wrongAck=%b ackAfter=%b want 1 0 0 0", rd, er, wa, aa);
    end
  endtask

  task automatic test_round_robin();
    bit   order_b[4];
    int   ack_at[4];
    int   n_acks = 0;
    int   n_ackb = 0;
    bit   both = 1'b0;
    bit   exp_b[4];
    int   exp_nb;
`ifdef JK_ARB_RR_EN
    exp_b = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_nb = 2;
`else
    exp_b = '{1'b0, 1'b0, 1'b0, 1'b0};
    exp_nb = 0;
`endif
    do_reset();
    ReqA = 1'b1; OpA = c_TGL; IdxA = 2'd1;
    ReqB = 1'b1; OpB = c_TGL; IdxB = 2'd3;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (AckA && AckB) both = 1'b1;
      if (AckB) n_ackb++;
      if ((AckA || AckB) && n_acks < 4) begin
        order_b[n_acks] = AckB;
        ack_at[n_acks]  = c;
        n_acks++;
      end
    end
    ReqA = 1'b0; ReqB = 1'b0;
    tick(); tick();
    n_checks++;
    if (n_acks !== 4 || both) begin
      n_fail++; $display("FAIL rr_ack_count: got %0d acks (both=%b) want 4 acks, never both", n_acks, both);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (order_b[i] !== exp_b[i] || ack_at[i] !== 3 + 4 * i) begin
        n_fail++;
        $display("FAIL rr_grant_%0d: got %s at cycle %0d want %s at cycle %0d",
                 i, order_b[i] ? "B" : "A", ack_at[i], exp_b[i] ? "B" : "A", 3 + 4 * i);
      end
    end
    n_checks++;
    if (n_ackb !== exp_nb) begin
      n_fail++; $display("FAIL rr_ackb_count: got %0d want %0d", n_ackb, exp_nb);
    end
  endtask

  task automatic test_clear_all();
    logic [3:0] gj, gk, sj, sk;
    logic gclrn, gpren, sclrn, spren, rd, er, aa;
    int ac;
    bit wa;
    do_reset();
    run_op(1'b0, c_PRA, 2'd0, gj, gk, gclrn, gpren, sj, sk, sclrn, spren, ac, rd, er, wa, aa);
    n_checks++;
    if ({gpren, spren, rd, er, Q} !== 8'b0_1_1_0_1111) begin
      n_fail++; $display("FAIL preset_all: got PreN grant=%b settle=%b Rd=%b Err=%b Q=%b want 0 1 1 0 1111",
                         gpren, spren, rd, er, Q);
    end
    run_op(1'b1, c_CLA, 2'd0, gj, gk, gclrn, gpren, sj, sk, sclrn, spren, ac, rd, er, wa, aa);
    n_checks++;
    if ({gclrn, sclrn, gpren, gj, gk} !== 11'b0_1_1_0000_0000) begin
      n_fail++; $display("FAIL clear_all_drive: got ClrN grant=%b settle=%b PreN=%b J=%b K=%b want 0 1 1 0000 0000",
                         gclrn, sclrn, gpren, gj, gk);
    end
    n_checks++;
    if (ac !== 3 || er !== 1'b0 || wa !== 1'b0) begin
      n_fail++; $display("FAIL clear_all_ackb: got ackcyc=%0d Err=%b wrongAck=%b want 3 0 0", ac, er, wa);
    end
    run_op(1'b0, c_RD, 2'd0, gj, gk, gclrn, gpren, sj, sk, sclrn, spren, ac, rd, er, wa, aa);
    n_checks++;
    if ({rd, er, gj, gk} !== 10'b0_0_0000_0000 || ac !== 3) begin
      n_fail++; $display("FAIL read_after_clear: got Rd=%b Err=%b J=%b K=%b ackcyc=%0d want 0 0 0000 0000 3",
                         rd, er, gj, gk, ac);
    end
  endtask

  task automatic test_toggle_twice();
    logic [3:0] gj, gk, sj, sk;
    logic gclrn, gpren, sclrn, spren, rd, er, aa;
    int ac;
    bit wa;
    do_reset();
    run_op(1'b0, c_CLA, 2'd0, gj, gk, gclrn, gpren, sj, sk, sclrn, spren, ac, rd, er, wa, aa);
    run_op(1'b0, c_TGL, 2'd1, gj, gk, gclrn, gpren, sj, sk, sclrn, spren, ac, rd, er, wa, aa);
    n_checks++;
    if ({gj, gk, rd, er} !== 10'b0010_0010_1_0) begin
      n_fail++; $display("FAIL toggle_first: got J=%b K=%b Rd=%b Err=%b want 0010 0010 1 0", gj, gk, rd, er);
    end
    run_op(1'b0, c_TGL, 2'd1, gj, gk, gclrn, gpren, sj, sk, sclrn, spren, ac, rd, er, wa, aa);
    n_checks++;
    if ({rd, er} !== 2'b00 || ac !== 3) begin
      n_fail++; $display("FAIL toggle_second: got Rd=%b Err=%b ackcyc=%0d want 0 0 3", rd, er, ac);
    end
    run_op(1'b0, c_RST, 2'd3, gj, gk, gclrn, gpren, sj, sk, sclrn, spren, ac, rd, er, wa, aa);
    n_checks++;
    if ({gj, gk, rd} !== 9'b0000_1000_0) begin
      n_fail++; $display("FAIL reset_bit: got J=%b K=%b Rd=%b want 0000 1000 0", gj, gk, rd);
    end
  endtask

  task automatic test_out_of_range();
    logic [2:0] jk;
    logic rd, er;
    int ac;
    do_reset();
    run_op3(c_SET, 2'd3, jk, ac, rd, er);
    n_checks++;
    if (jk !== 3'b000 || ac !== 3 || {rd, er} !== 2'b01) begin
      n_fail++; $display("FAIL oor_set: got JK=%b ackcyc=%0d Rd=%b Err=%b want 000 3 0 1", jk, ac, rd, er);
    end
    run_op3(c_RD, 2'd3, jk, ac, rd, er);
    n_checks++;
    if ({rd, er} !== 2'b01 || ac !== 3) begin
      n_fail++; $display("FAIL oor_read: got Rd=%b Err=%b ackcyc=%0d want 0 1 3", rd, er, ac);
    end
    run_op3(c_NOP, 2'd3, jk, ac, rd, er);
    n_checks++;
    if ({rd, er} !== 2'b00 || ac !== 3) begin
      n_fail++; $display("FAIL oor_nop_err: got Rd=%b Err=%b ackcyc=%0d want 0 0 3", rd, er, ac);
    end
    run_op3(c_SET, 2'd2, jk, ac, rd, er);
    n_checks++;
    if (jk !== 3'b100 || {rd, er} !== 2'b10) begin
      n_fail++; $display("FAIL w3_top_bit: got JK=%b Rd=%b Err=%b want 100 1 0", jk, rd, er);
    end
  endtask

  task automatic test_clr_abort();
    logic [3:0] gj, gk, sj, sk;
    logic gclrn, gpren, sclrn, spren, rd, er, aa;
    int ac;
    bit wa;
    bit seen = 1'b0;
    do_reset();
    ReqA = 1'b1; OpA = c_PRA; IdxA = 2'd0;
    tick();
    n_checks++;
    if (PreN !== 1'b0 || Busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_grant: got PreN=%b Busy=%b want 0 1", PreN, Busy);
    end
    Clr = 1'b1;
    tick();
    Clr = 1'b0; ReqA = 1'b0;
    n_checks++;
    if ({PreN, ClrN, Busy, AckA, AckB} !== 5'b11000) begin
      n_fail++; $display("FAIL abort_release: got PreN=%b ClrN=%b Busy=%b AckA=%b AckB=%b want 1 1 0 0 0",
                         PreN, ClrN, Busy, AckA, AckB);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      if (AckA || AckB || Busy) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL abort_no_ack: got ack/busy activity after abort, want none");
    end
    run_op(1'b1, c_RD, 2'd0, gj, gk, gclrn, gpren, sj, sk, sclrn, spren, ac, rd, er, wa, aa);
    n_checks++;
    if (ac !== 3 || {rd, er, wa} !== 3'b100) begin
      n_fail++; $display("FAIL abort_then_b: got ackcyc=%0d Rd=%b Err=%b wrongAck=%b want 3 1 0 0", ac, rd, er, wa);
    end
  endtask

  initial begin
    test_reset();
    test_set();
    test_round_robin();
    test_clear_all();
    test_toggle_twice();
    test_out_of_range();
    test_clr_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
